text_buffer_writer: RTL and testbench

- Producer side of the character-display path: accepts a byte stream of typed characters and control codes and maintains a 32-column x 4-row character buffer of 128 cells x 7 bits.
- Serves the 7-bit ascii_code that the pixel renderer consumes for the centre text window, x 192..447 and y 208..271, with 8x16 glyphs.
- Sits between the keyboard/UART receive path and the text renderer.
- Owns the cursor, plus clear, backspace, newline and wrap handling.

---
 rtl/text_buffer_writer.sv | 202 ++++++++++++++++++++
 tb/tb_text_buffer_writer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_buffer_writer.sv
// text_buffer_writer
//   Producer side of the character display. Accepts typed characters and control
//   codes, maintains a 32x4 character buffer (128 cells x 7 bits, address
//   {row, col}), and serves the glyph code under the current pixel of the text
//   window (x 192..447, y 208..271, 8x16 glyphs) to the renderer.
//
//   Optional feature macro: TEXT_BUF_SCROLL_EN. When defined, moving past row 3
//   scrolls the buffer up one row. Otherwise the cursor wraps to (0,0).
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   din, din_valid      input byte and its valid strobe
//   din_ready           byte accepted this cycle when din_valid is also high
//   x, y                current pixel position from the sync generator
//   ascii_code          registered cell code under (x,y), BLANK outside window
//   cur_col, cur_row    cursor position
//   busy                clear or scroll sequence in progress
module text_buffer_writer #(
  parameter int unsigned WIN_X0 = 192,
  parameter int unsigned WIN_Y0 = 208,
  parameter logic [6:0]  BLANK  = 7'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic [6:0] ascii_code,
  output logic [4:0] cur_col,
  output logic [1:0] cur_row,
  output logic       busy
);

  typedef enum logic [1:0] {StClear, StIdle, StScroll} state_e;

  state_e     state_q, state_d;
  logic [7:0] idx_q, idx_d;     // clear index 0..127, scroll step 0..223
  logic [4:0] col_q, col_d;
  logic [1:0] row_q, row_d;

  logic [6:0] mem [128];
  logic       we;
  logic [6:0] waddr;
  logic [6:0] wdata;
  logic       adv_row;
  logic       is_print;

  // Display read address decode
  logic [9:0] dx, dy;
  logic       in_win;
  logic [6:0] raddr;

  assign dx     = x - 10'(WIN_X0);
  assign dy     = y - 10'(WIN_Y0);
  assign in_win = (x >= 10'(WIN_X0)) && (dx < 10'd256) &&
                  (y >= 10'(WIN_Y0)) && (dy < 10'd64);
  assign raddr  = {dy[5:4], dx[7:3]};

  assign is_print = (din >= 8'h20) && (din <= 8'h7E);
  assign cur_col  = col_q;
  assign cur_row  = row_q;

`ifdef TEXT_BUF_SCROLL_EN
  // Internal read port for the scroll copy: even steps read cell i+32, odd steps
  // write the captured value to cell i.
  logic [6:0] scroll_rd_q;

  always_ff @(posedge clk) begin
    scroll_rd_q <= mem[idx_q[7:1] + 7'd32];
  end
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    col_d     = col_q;
    row_d     = row_q;
    we        = 1'b0;
    waddr     = {row_q, col_q};
    wdata     = BLANK;
    din_ready = 1'b0;
    busy      = 1'b0;
    adv_row   = 1'b0;

    unique case (state_q)
      StClear: begin
        busy  = 1'b1;
        we    = 1'b1;
        waddr = idx_q[6:0];
        if (idx_q == 8'd127) begin
          state_d = StIdle;
          idx_d   = 8'd0;
          col_d   = 5'd0;
          row_d   = 2'd0;
        end else begin
          idx_d = idx_q + 8'd1;
        end
      end

      StIdle: begin
        din_ready = 1'b1;
        if (din_valid) begin
          if (is_print) begin
            we    = 1'b1;
            wdata = din[6:0];
            if (col_q == 5'd31) begin
              col_d   = 5'd0;
              adv_row = 1'b1;
            end else begin
              col_d = col_q + 5'd1;
            end
          end else if (din == 8'h08) begin
            if (col_q != 5'd0) begin
              col_d = col_q - 5'd1;
              we    = 1'b1;
              waddr = {row_q, col_q - 5'd1};
            end else if (row_q != 2'd0) begin
              col_d = 5'd31;
              row_d = row_q - 2'd1;
              we    = 1'b1;
              waddr = {row_q - 2'd1, 5'd31};
            end
          end else if ((din == 8'h0A) || (din == 8'h0D)) begin
            col_d   = 5'd0;
            adv_row = 1'b1;
          end else if (din == 8'h0C) begin
            state_d = StClear;
            idx_d   = 8'd0;
          end

          if (adv_row) begin
`ifdef TEXT_BUF_SCROLL_EN
            if (row_q == 2'd3) begin
              state_d = StScroll;
              idx_d   = 8'd0;
            end else begin
              row_d = row_q + 2'd1;
            end
`else
            row_d = row_q + 2'd1;  // 3 wraps to 0, text overwritten in place
`endif
          end
        end
      end

`ifdef TEXT_BUF_SCROLL_EN
      StScroll: begin
        busy = 1'b1;
        if (idx_q < 8'd192) begin
          if (idx_q[0]) begin
            we    = 1'b1;
            waddr = idx_q[7:1];
            wdata = scroll_rd_q;
          end
        end else begin
          we    = 1'b1;
          waddr = 7'(idx_q - 8'd96);  // steps 192..223 blank cells 96..127
        end
        if (idx_q == 8'd223) begin
          state_d = StIdle;
          idx_d   = 8'd0;
          col_d   = 5'd0;
          row_d   = 2'd3;
        end else begin
          idx_d = idx_q + 8'd1;
        end
      end
`endif

      default: begin
        state_d = StClear;
        idx_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StClear;
      idx_q      <= 8'd0;
      col_q      <= 5'd0;
      row_q      <= 2'd0;
      ascii_code <= BLANK;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      col_q      <= col_d;
      row_q      <= row_d;
      ascii_code <= in_win ? mem[raddr] : BLANK;
    end
  end

  // Write port; a same-cycle display read of this cell sees the old value.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

endmodule

// File: tb/tb_text_buffer_writer.sv
module tb_text_buffer_writer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic [9:0] x = 10'd0;
  logic [9:0] y = 10'd0;
  logic [6:0] ascii_code;
  logic [4:0] cur_col;
  logic [1:0] cur_row;
  logic       busy;

  int checks = 0;
  int errors = 0;

  text_buffer_writer dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .x         (x),
    .y         (y),
    .ascii_code(ascii_code),
    .cur_col   (cur_col),
    .cur_row   (cur_row),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic [4:0] col;
    logic [1:0] row;
  } byte_vec_t;

  typedef struct {
    logic [9:0] px;
    logic [9:0] py;
    logic [6:0] code;
  } rd_vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) until din_ready is high, returns cycles waited.
  task automatic wait_ready(output int n);
    n = 0;
    while (!din_ready && n < 1000) begin
      tick();
      n++;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    din       = b;
    din_valid = 1'b1;
    wait_ready(n);
    check("send_ready", {31'd0, din_ready}, 32'd1);
    tick();
    din_valid = 1'b0;
  endtask

  task automatic read_xy(input logic [9:0] px, input logic [9:0] py, output logic [6:0] c);
    x = px;
    y = py;
    tick();
    c = ascii_code;
  endtask

  task automatic read_cell(input int a, output logic [6:0] c);
    read_xy(10'(192 + 8 * (a % 32)), 10'(208 + 16 * (a / 32)), c);
  endtask

  function automatic logic [6:0] fill_code(input int i);
    return 7'(48 + (i % 64));
  endfunction

  byte_vec_t vec_a [2];
  byte_vec_t vec_b [9];
  rd_vec_t   rd_a  [8];

  initial begin
    logic [6:0] c;
    int n;
    int bad;

    vec_a[0] = '{8'h48, 5'd1, 2'd0};
    vec_a[1] = '{8'h69, 5'd2, 2'd0};

    rd_a[0] = '{10'd200, 10'd210, 7'h69};
    rd_a[1] = '{10'd192, 10'd208, 7'h48};
    rd_a[2] = '{10'd100, 10'd210, 7'h20};
    rd_a[3] = '{10'd191, 10'd208, 7'h20};
    rd_a[4] = '{10'd199, 10'd223, 7'h48};
    rd_a[5] = '{10'd200, 10'd224, 7'h20};
    rd_a[6] = '{10'd448, 10'd208, 7'h20};
    rd_a[7] = '{10'd192, 10'd207, 7'h20};

    vec_b[0] = '{8'h08, 5'd1,  2'd0};
    vec_b[1] = '{8'h08, 5'd0,  2'd0};
    vec_b[2] = '{8'h08, 5'd0,  2'd0};
    vec_b[3] = '{8'h85, 5'd0,  2'd0};
    vec_b[4] = '{8'h07, 5'd0,  2'd0};
    vec_b[5] = '{8'h0A, 5'd0,  2'd1};
    vec_b[6] = '{8'h08, 5'd31, 2'd0};
    vec_b[7] = '{8'h42, 5'd0,  2'd1};
    vec_b[8] = '{8'h08, 5'd31, 2'd0};

    // Reset and initial clear
    tick();
    tick();
    check("rst_ascii", {25'd0, ascii_code}, 32'h20);
    check("rst_col", {27'd0, cur_col}, 32'd0);
    check("rst_row", {30'd0, cur_row}, 32'd0);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 128; i++) begin
      if (!(busy && !din_ready)) bad++;
      tick();
    end
    check("clear_busy_128", bad, 0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_ready", {31'd0, din_ready}, 32'd1);
    bad = 0;
    for (int i = 0; i < 128; i++) begin
      read_cell(i, c);
      if (c !== 7'h20) bad++;
    end
    check("clear_all_blank", bad, 0);

    // Printable characters and display reads
    foreach (vec_a[i]) begin
      send_byte(vec_a[i].b);
      check("print_col", {27'd0, cur_col}, {27'd0, vec_a[i].col});
      check("print_row", {30'd0, cur_row}, {30'd0, vec_a[i].row});
    end
    foreach (rd_a[i]) begin
      read_xy(rd_a[i].px, rd_a[i].py, c);
      check("disp_read", {25'd0, c}, {25'd0, rd_a[i].code});
    end

    // Output is registered: moving x shows up only after the next edge
    read_xy(10'd192, 10'd208, c);
    x = 10'd200;
    #1;
    check("disp_latency_hold", {25'd0, ascii_code}, 32'h48);
    tick();
    check("disp_latency_new", {25'd0, ascii_code}, 32'h69);

    // Backspace, ignored codes, newline, backspace across a row
    foreach (vec_b[i]) begin
      send_byte(vec_b[i].b);
      check("ctrl_col", {27'd0, cur_col}, {27'd0, vec_b[i].col});
      check("ctrl_row", {30'd0, cur_row}, {30'd0, vec_b[i].row});
    end
    read_cell(0, c);
    check("bs_cell0", {25'd0, c}, 32'h20);
    read_cell(1, c);
    check("bs_cell1", {25'd0, c}, 32'h20);
    read_cell(31, c);
    check("bs_cell31", {25'd0, c}, 32'h20);

    send_byte(8'h0C);
    check("ff_busy", {31'd0, busy}, 32'd1);
    wait_ready(n);
    check("ff_clear_len", n, 128);

    // 33 'A' then CR then form feed
    for (int i = 0; i < 33; i++) send_byte(8'h41);
    check("a33_col", {27'd0, cur_col}, 32'd1);
    check("a33_row", {30'd0, cur_row}, 32'd1);
    bad = 0;
    for (int i = 0; i < 34; i++) begin
      read_cell(i, c);
      if (c !== ((i < 33) ? 7'h41 : 7'h20)) bad++;
    end
    check("a33_cells", bad, 0);
    send_byte(8'h0D);
    check("cr_col", {27'd0, cur_col}, 32'd0);
    check("cr_row", {30'd0, cur_row}, 32'd2);

    // Form feed with din_valid held through the clear
    send_byte(8'h0C);
    din       = 8'h42;
    din_valid = 1'b1;
    wait_ready(n);
    check("hold_wait_len", n, 128);
    tick();
    din_valid = 1'b0;
    check("hold_col", {27'd0, cur_col}, 32'd1);
    bad = 0;
    for (int i = 0; i < 128; i++) begin
      read_cell(i, c);
      if (c !== ((i == 0) ? 7'h42 : 7'h20)) bad++;
    end
    check("hold_cells", bad, 0);

    // Fill to (31,3), then one more character
    send_byte(8'h0C);
    wait_ready(n);
    for (int i = 0; i < 127; i++) send_byte({1'b0, fill_code(i)});
    check("fill_col", {27'd0, cur_col}, 32'd31);
    check("fill_row", {30'd0, cur_row}, 32'd3);
    send_byte(8'h5A);
`ifdef TEXT_BUF_SCROLL_EN
    check("scroll_busy", {31'd0, busy}, 32'd1);
    wait_ready(n);
    check("scroll_len", n, 224);
    check("scroll_col", {27'd0, cur_col}, 32'd0);
    check("scroll_row", {30'd0, cur_row}, 32'd3);
    bad = 0;
    for (int i = 0; i < 128; i++) begin
      read_cell(i, c);
      if (i < 95) begin
        if (c !== fill_code(i + 32)) bad++;
      end else if (i == 95) begin
        if (c !== 7'h5A) bad++;
      end else if (c !== 7'h20) bad++;
    end
    check("scroll_cells", bad, 0);
`else
    check("wrap_busy", {31'd0, busy}, 32'd0);
    check("wrap_col", {27'd0, cur_col}, 32'd0);
    check("wrap_row", {30'd0, cur_row}, 32'd0);
    bad = 0;
    for (int i = 0; i < 128; i++) begin
      read_cell(i, c);
      if (c !== ((i == 127) ? 7'h5A : fill_code(i))) bad++;
    end
    check("wrap_cells", bad, 0);
    send_byte(8'h51);
    read_cell(0, c);
    check("wrap_overwrite", {25'd0, c}, 32'h51);
    check("wrap_next_col", {27'd0, cur_col}, 32'd1);
`endif

    // Reset in the middle of a clear restarts it from index 0
    send_byte(8'h0C);
    repeat (50) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd1);
    wait_ready(n);
    check("midrst_len", n, 128);
    check("midrst_col", {27'd0, cur_col}, 32'd0);
    check("midrst_row", {30'd0, cur_row}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
